// File: rtl/rca_nibble_sched_if.sv
// rtl/rca_nibble_sched_if.sv - requester and response bundle for the nibble-serial add scheduler
interface rca_nibble_sched_if #(
  parameter int NIBBLES = 4
);
  localparam int WIDTH = 4 * NIBBLES;

  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;
  logic             req0_ready;

  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;
  logic             req1_ready;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_id;

  // Requesters and response consumer side
  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

  // Scheduler side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_sum, rsp_cout, rsp_id
  );
endinterface

// File: rtl/rca_nibble_sched.sv
// rtl/rca_nibble_sched.sv - round-robin scheduler driving a shared 4-bit adder nibble-serially
module rca_nibble_sched #(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  rca_nibble_sched_if.slave        bus,
  output logic [3:0]               rca_a,
  output logic [3:0]               rca_b,
  output logic                     rca_cin,
  input  logic [3:0]               rca_s,
  input  logic                     rca_cout
);
  localparam int WIDTH = 4 * NIBBLES;
  localparam int IW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic grant0, grant1;

  // Round-robin grant; prio only breaks ties. Held off during reset so a ready
  // is never shown for a cycle whose acceptance reset would discard.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if ((state_q == IDLE) && !rst) begin
      grant0 = bus.req0_valid && (!bus.req1_valid || (prio_q == 1'b0));
      grant1 = bus.req1_valid && (!bus.req0_valid || (prio_q == 1'b1));
    end
  end

  // Next-state: capture on grant, one nibble per ADD cycle, hold in RESP until taken
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          state_d = ADD;
          id_d    = grant1;
          a_d     = grant1 ? bus.req1_a   : bus.req0_a;
          b_d     = grant1 ? bus.req1_b   : bus.req0_b;
          carry_d = grant1 ? bus.req1_cin : bus.req0_cin;
          idx_d   = '0;
        end
      end
      ADD: begin
        sum_d[4*idx_q +: 4] = rca_s;
        carry_d             = rca_cout;
        if (idx_q == LAST_IDX) begin
          state_d = RESP;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          prio_d  = ~id_q;
        end
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP);
  end

  // State registers; reset wins over any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Adder operands are only presented while walking the nibbles
  always_comb begin
    rca_a   = 4'd0;
    rca_b   = 4'd0;
    rca_cin = 1'b0;
    if (state_q == ADD) begin
      rca_a   = a_q[4*idx_q +: 4];
      rca_b   = b_q[4*idx_q +: 4];
      rca_cin = carry_q;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_sum    = sum_q;
  assign bus.rsp_cout   = carry_q;
  assign bus.rsp_id     = id_q;
endmodule

// File: tb/tb_rca_nibble_sched.sv
// tb/tb_rca_nibble_sched.sv - self-checking bench for rca_nibble_sched
module tb_rca_nibble_sched;
  localparam int NIBBLES = 4;
  localparam int WIDTH   = 4 * NIBBLES;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rca_a, rca_b, rca_s;
  logic       rca_cin, rca_cout;

  always #5 clk = ~clk;

  rca_nibble_sched_if #(.NIBBLES(NIBBLES)) bus ();

  rca_nibble_sched #(.NIBBLES(NIBBLES)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rca_a    (rca_a),
    .rca_b    (rca_b),
    .rca_cin  (rca_cin),
    .rca_s    (rca_s),
    .rca_cout (rca_cout)
  );

  // External 4-bit adder
  assign {rca_cout, rca_s} = {1'b0, rca_a} + {1'b0, rca_b} + {4'd0, rca_cin};

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    int               stall;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  endfunction

  // Carry into nibble k: carry out of adding the low 4k bits of both operands plus cin
  function automatic logic nib_carry(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic cin, input int k);
    logic [63:0] mask, t;
    mask = (64'd1 << (4 * k)) - 64'd1;
    t    = (64'(a) & mask) + (64'(b) & mask) + 64'(cin);
    return t[4*k];
  endfunction

  task automatic set_req(input logic id, input logic v, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic cin);
    if (id == 1'b0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin;
    end
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  // Ends at the negedge where the requester's ready is seen
  task automatic wait_ready(input logic id, output logic got);
    got = 1'b0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (((id == 1'b0) ? bus.req0_ready : bus.req1_ready) === 1'b1) begin
        got = 1'b1;
        break;
      end
      next_drive();
    end
  endtask

  // Ends at the negedge where rsp_valid is seen
  task automatic wait_rsp(output logic got);
    got = 1'b0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      next_drive();
    end
  endtask

  // One request from a single requester, checked cycle by cycle; starts and ends just after a posedge
  task automatic run_single(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic cin, input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                            input int stall, input string tag);
    logic got;
    bus.rsp_ready = (stall == 0);
    set_req(id, 1'b1, a, b, cin);
    wait_ready(id, got);
    chk({tag, " accept"}, 64'(got), 64'd1);
    if (!got) begin
      set_req(id, 1'b0, '0, '0, 1'b0);
      next_drive();
      return;
    end
    chk({tag, " other ready"}, 64'((id == 1'b0) ? bus.req1_ready : bus.req0_ready), 64'd0);
    next_drive();
    set_req(id, 1'b0, '0, '0, 1'b0);
    for (int k = 0; k < NIBBLES; k++) begin
      @(negedge clk);
      chk($sformatf("%s add%0d rca_a", tag, k), 64'(rca_a), 64'(a[4*k +: 4]));
      chk($sformatf("%s add%0d rca_b", tag, k), 64'(rca_b), 64'(b[4*k +: 4]));
      chk($sformatf("%s add%0d rca_cin", tag, k), 64'(rca_cin), 64'(nib_carry(a, b, cin, k)));
      chk($sformatf("%s add%0d rca_s", tag, k), 64'(rca_s), 64'(exp_sum[4*k +: 4]));
      chk($sformatf("%s add%0d rsp_valid", tag, k), 64'(bus.rsp_valid), 64'd0);
      next_drive();
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk($sformatf("%s stall%0d", tag, s), {bus.rsp_valid, bus.rsp_id, bus.rsp_sum},
          {1'b1, id, exp_sum});
      next_drive();
      if (s == stall - 1) bus.rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, " rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({tag, " rsp_sum"}, 64'(bus.rsp_sum), 64'(exp_sum));
    chk({tag, " rsp_cout"}, 64'(bus.rsp_cout), 64'(exp_cout));
    chk({tag, " rsp_id"}, 64'(bus.rsp_id), 64'(id));
    next_drive();
    @(negedge clk);
    chk({tag, " rsp drop"}, 64'(bus.rsp_valid), 64'd0);
    next_drive();
  endtask

  logic             got;
  logic             seen;
  logic [WIDTH:0]   r;
  logic             q_gid[$];
  int               q_gcyc[$];
  logic             q_rid[$];
  logic [WIDTH-1:0] q_rsum[$];

  initial begin
    vecs[0] = '{1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 0};
    vecs[1] = '{1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 0};
    vecs[2] = '{1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1};
    vecs[3] = '{1'b1, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 2};
    vecs[4] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0};
    vecs[5] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 3};

    rst = 1'b1;
    set_req(1'b0, 1'b0, '0, '0, 1'b0);
    set_req(1'b1, 1'b0, '0, '0, 1'b0);
    bus.rsp_ready = 1'b0;

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("reset outputs c%0d", c),
          64'({bus.rsp_valid, bus.rsp_sum, bus.rsp_cout, bus.rsp_id, rca_a, rca_b, rca_cin,
               bus.req0_ready, bus.req1_ready}), 64'd0);
    end
    next_drive();
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_single(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum,
                 vecs[i].exp_cout, vecs[i].stall, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 30; i++) begin
      logic             rid;
      logic [WIDTH-1:0] ra, rb;
      logic             rc;
      rid = 1'($urandom_range(0, 1));
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      rc  = 1'($urandom_range(0, 1));
      r   = ref_add(ra, rb, rc);
      run_single(rid, ra, rb, rc, r[WIDTH-1:0], r[WIDTH], int'($urandom_range(0, 2)),
                 $sformatf("rnd%0d", i));
    end

    // Both requesters held valid: alternation starting from 0 after reset
    rst = 1'b1;
    next_drive();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0);
    set_req(1'b1, 1'b1, 16'h1234, 16'h4321, 1'b0);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.req0_ready && bus.req1_ready) chk("both ready", 64'd1, 64'd0);
      if (bus.req0_ready) begin q_gid.push_back(1'b0); q_gcyc.push_back(c); end
      if (bus.req1_ready) begin q_gid.push_back(1'b1); q_gcyc.push_back(c); end
      if (bus.rsp_valid) begin q_rid.push_back(bus.rsp_id); q_rsum.push_back(bus.rsp_sum); end
      if (q_rid.size() == 4) break;
      next_drive();
    end
    next_drive();
    set_req(1'b0, 1'b0, '0, '0, 1'b0);
    set_req(1'b1, 1'b0, '0, '0, 1'b0);
    chk("rr response count", 64'(q_rid.size()), 64'd4);
    chk("rr grant count", 64'(q_gid.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      r = (i % 2 == 0) ? ref_add(16'h1111, 16'h2222, 1'b0) : ref_add(16'h1234, 16'h4321, 1'b0);
      if (q_gid.size() > i) chk($sformatf("rr grant%0d", i), 64'(q_gid[i]), 64'(i % 2));
      if (q_gcyc.size() > i && i > 0)
        chk($sformatf("rr spacing%0d", i), 64'(q_gcyc[i] - q_gcyc[i-1]), 64'(NIBBLES + 2));
      if (q_rid.size() > i) begin
        chk($sformatf("rr rsp id%0d", i), 64'(q_rid[i]), 64'(i % 2));
        chk($sformatf("rr rsp sum%0d", i), 64'(q_rsum[i]), 64'(r[WIDTH-1:0]));
      end
    end
    @(negedge clk);
    chk("rr idle after", 64'(bus.rsp_valid), 64'd0);
    next_drive();

    // Response backpressure with req1 waiting
    set_req(1'b0, 1'b1, 16'hA5A5, 16'h0F0F, 1'b0);
    bus.rsp_ready = 1'b0;
    wait_ready(1'b0, got);
    chk("bp accept", 64'(got), 64'd1);
    next_drive();
    set_req(1'b0, 1'b0, '0, '0, 1'b0);
    set_req(1'b1, 1'b1, 16'h0001, 16'h0002, 1'b1);
    wait_rsp(got);
    chk("bp rsp seen", 64'(got), 64'd1);
    r = ref_add(16'hA5A5, 16'h0F0F, 1'b0);
    for (int s = 0; s < 3; s++) begin
      if (s > 0) @(negedge clk);
      chk($sformatf("bp hold%0d", s), {bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.req1_ready},
          {1'b1, 1'b0, r[WIDTH-1:0], 1'b0});
      next_drive();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp handshake", {bus.rsp_valid, bus.req1_ready}, 64'b10);
    next_drive();
    @(negedge clk);
    chk("bp req1 grant", {bus.rsp_valid, bus.req1_ready}, 64'b01);
    next_drive();
    set_req(1'b1, 1'b0, '0, '0, 1'b0);
    wait_rsp(got);
    r = ref_add(16'h0001, 16'h0002, 1'b1);
    chk("bp req1 rsp", {got, bus.rsp_id, bus.rsp_sum}, {1'b1, 1'b1, r[WIDTH-1:0]});
    next_drive();

    // Leave prio pointing at requester 1, then abort a req0 add with reset
    run_single(1'b0, 16'h0F00, 16'h0100, 1'b0, 16'h1000, 1'b0, 0, "pre_abort");
    set_req(1'b0, 1'b1, 16'h1234, 16'h1111, 1'b0);
    wait_ready(1'b0, got);
    chk("abort accept", 64'(got), 64'd1);
    next_drive();
    set_req(1'b0, 1'b0, '0, '0, 1'b0);
    next_drive();
    rst = 1'b1;
    next_drive();
    rst = 1'b0;
    @(negedge clk);
    chk("abort idle outputs",
        64'({bus.rsp_valid, bus.rsp_sum, bus.rsp_cout, bus.rsp_id, rca_a, rca_b, rca_cin}), 64'd0);
    next_drive();
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
      next_drive();
    end
    chk("abort no response", 64'(seen), 64'd0);
    set_req(1'b0, 1'b1, 16'h0003, 16'h0004, 1'b0);
    set_req(1'b1, 1'b1, 16'h0005, 16'h0006, 1'b0);
    @(negedge clk);
    chk("abort prio cleared", {bus.req0_ready, bus.req1_ready}, 64'b10);
    next_drive();
    set_req(1'b0, 1'b0, '0, '0, 1'b0);
    set_req(1'b1, 1'b0, '0, '0, 1'b0);
    wait_rsp(got);
    chk("abort followup rsp", {got, bus.rsp_id, bus.rsp_sum}, {1'b1, 1'b0, 16'h0007});
    next_drive();
    run_single(1'b1, 16'h4000, 16'h0ABC, 1'b1, 16'h4ABD, 1'b0, 0, "post_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/rca_nibble_sched.md
# rca_nibble_sched

Scheduler that shares one 4-bit ripple-carry adder (`rca`: ports a, b, cin, s, cout) between two requesters and uses it nibble-serially to add wide operands. It arbitrates round-robin, accepts one WIDTH-bit add per grant, and walks the operands through the adder one nibble per cycle, least-significant first, chaining the carry through a register. It then returns the sum on a valid/ready response port. The `rca` instance sits outside this block and connects through the `rca_*` ports.

## Interface
- NIBBLES, default 4: number of 4-bit slices per operand. WIDTH = 4*NIBBLES. Minimum 1.
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid  in  1  requester 0 has an add pending.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req0_ready  out  1  requester 0 is accepted this cycle.
- req1_valid, req1_a, req1_b, req1_cin, req1_ready: same as requester 0, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_sum  out  WIDTH  sum.
- rsp_cout  out  1  carry out of the top nibble.
- rsp_id  out  1  index of the requester that is served.
- rca_a, rca_b  out  4  adder operand nibbles.
- rca_cin  out  1  adder carry-in.
- rca_s  in  4  adder sum. Combinational from the rca_* outputs.
- rca_cout  in  1  adder carry-out.

## Operation
- The FSM has three states: IDLE, ADD and RESP.
- **IDLE**
  - If no valid is asserted, stay in IDLE.
  - If exactly one valid is asserted, that requester is granted.
  - If both are asserted, the requester named by priority pointer `prio` is granted.
  - `reqX_ready` = (state==IDLE) && grantX. It is combinational and never high for both requesters.
  - On the grant cycle, capture a, b and cin (into `carry`) and the id. Clear `idx` to 0. Go to ADD.
- **ADD**
  - Drive rca_a = a_reg[4*idx+:4], rca_b = b_reg[4*idx+:4], rca_cin = carry.
  - Each cycle, register sum_reg[4*idx+:4] <= rca_s and carry <= rca_cout.
  - If idx == NIBBLES-1, go to RESP. Otherwise idx <= idx+1.
  - rca_a, rca_b and rca_cin are 0 in every state other than ADD.
- **RESP**
  - rsp_valid = 1. rsp_sum = sum_reg, rsp_cout = carry, rsp_id = served id.
  - All response outputs are held stable until rsp_valid && rsp_ready.
  - On that handshake: go to IDLE, set prio <= ~rsp_id, and deassert rsp_valid on the next cycle.
- Requesters hold valid and data stable until they see ready. No request is accepted outside IDLE.
- Arithmetic is modulo 2^WIDTH.
  - Carry out of the top nibble goes only to rsp_cout.
  - All-ones + 0 + cin=1 wraps to sum 0 with cout 1.
- rsp_sum and rsp_cout keep their last value after the handshake. They are only meaningful while rsp_valid=1.

## Timing
- **Reset values:** state=IDLE, prio=0, idx=0, carry=0, sum_reg=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, rca_a=rca_b=0, rca_cin=0, req0_ready=req1_ready=0.
- **Reset has priority over everything.** If rst is asserted in ADD or RESP:
  - The transaction is aborted and no response is ever produced.
  - The next cycle is IDLE with all reset values.
- **Latency:** accept at cycle T → ADD in T+1..T+NIBBLES → rsp_valid first high at T+NIBBLES+1.
- **Throughput:** at most one add per NIBBLES+2 cycles. This assumes rsp_ready is high; the extra cycles are IDLE and RESP.
- **NIBBLES=1:** a single ADD cycle, then RESP.
- **rsp_ready held high:** rsp_valid is high for exactly one cycle per transaction.
- **Back-to-back:** the cycle after the response handshake is IDLE, and a new grant may occur in that same cycle.

## Test plan
- Reset with both valids low for 3 cycles → every output 0, both readys 0, rca_* all 0.
- req0 a=0x00FF, b=0x0001, cin=0 accepted at T, rsp_ready=1 → at T+5 rsp_valid=1, rsp_sum=0x0100, rsp_cout=0, rsp_id=0. rca_cin sequence over ADD cycles is 0,1,1,0.
- req1 a=0xFFFF, b=0x0000, cin=1 → rsp_sum=0x0000, rsp_cout=1, rsp_id=1. rca_s=0 in every ADD cycle.
- Both valids held high:
  - req0 a=0x1111, b=0x2222; req1 a=0x1234, b=0x4321.
  - Grants alternate 0,1,0,1 starting with 0.
  - Responses are 0x3333 (id 0) and 0x5555 (id 1).
  - Accepts are spaced 6 cycles apart.
- rsp_ready held low for 3 cycles in RESP, with req1_valid=1 → rsp_valid, rsp_sum and rsp_id stay stable and req1_ready stays 0. Raising rsp_ready completes the handshake, and req1 is granted in the next cycle (IDLE).
- rst pulsed in the 2nd ADD cycle of a req0 add → next cycle IDLE, rsp_valid=0, prio=0. No response appears afterwards, and a new req1 request is then granted normally.
